// File: rtl/cpu_step_controller.sv
// Execution-rate controller: issues single-cycle cpu_enable strobes in free-run, single-step or halted mode.
// Optional feature macro: CPU_STEP_DEBOUNCE_EN (debounce counter on the step button path).
module cpu_step_controller #(
  parameter logic [27:0] DIVISOR         = 28'd10000000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        run_mode,
  input  logic        resume,
  input  logic        step_btn,
  input  logic        halt_req,
  output logic        cpu_enable,
  output logic [1:0]  state,
  output logic [31:0] pulse_count
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  logic        sync1_r;
  logic        btn_sync_r;
  logic        btn_db_s;
  logic        btn_db_d_r;
  logic        step_event_s;
  state_t      state_r;
  logic [27:0] div_cnt_r;
  logic        cpu_enable_r;
  logic [31:0] pulse_count_r;

  // Button synchronizer plus delayed copy of the debounced level for edge detection.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      btn_sync_r <= 1'b0;
      btn_db_d_r <= 1'b0;
    end else begin
      sync1_r    <= step_btn;
      btn_sync_r <= sync1_r;
      btn_db_d_r <= btn_db_s;
    end
  end

`ifdef CPU_STEP_DEBOUNCE_EN
  logic        btn_db_r;
  logic [19:0] db_cnt_r;

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      btn_db_r <= 1'b0;
      db_cnt_r <= 20'd0;
    end else if (btn_sync_r == btn_db_r) begin
      db_cnt_r <= 20'd0;
    end else if (db_cnt_r == DEBOUNCE_CYCLES - 20'd1) begin
      btn_db_r <= btn_sync_r;
      db_cnt_r <= 20'd0;
    end else begin
      db_cnt_r <= db_cnt_r + 20'd1;
    end
  end

  assign btn_db_s = btn_db_r;
`else
  logic unused_debounce_s;

  assign btn_db_s          = btn_sync_r;
  assign unused_debounce_s = ^DEBOUNCE_CYCLES;
`endif

  assign step_event_s = btn_db_s & ~btn_db_d_r;

  // Mode FSM; branch order encodes the transition priority, so a lower branch's pulse is simply not taken.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_r       <= ST_PAUSED;
      div_cnt_r     <= 28'd0;
      cpu_enable_r  <= 1'b0;
      pulse_count_r <= 32'd0;
    end else begin
      cpu_enable_r <= 1'b0;
      case (state_r)
        ST_PAUSED: begin
          if (halt_req) begin
            state_r <= ST_HALTED;
          end else if (resume && run_mode) begin
            state_r   <= ST_RUN;
            div_cnt_r <= 28'd0;
          end else if (step_event_s) begin
            cpu_enable_r  <= 1'b1;
            pulse_count_r <= pulse_count_r + 32'd1;
          end else begin
            state_r <= ST_PAUSED;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            state_r <= ST_HALTED;
          end else if (!run_mode) begin
            state_r   <= ST_PAUSED;
            div_cnt_r <= 28'd0;
          end else if (div_cnt_r == DIVISOR - 28'd1) begin
            div_cnt_r     <= 28'd0;
            cpu_enable_r  <= 1'b1;
            pulse_count_r <= pulse_count_r + 32'd1;
          end else begin
            div_cnt_r <= div_cnt_r + 28'd1;
          end
        end
        ST_HALTED: begin
          if (resume && !halt_req) begin
            state_r <= ST_PAUSED;
          end else begin
            state_r <= ST_HALTED;
          end
        end
        default: begin
          state_r <= ST_PAUSED;
        end
      endcase
    end
  end

  assign cpu_enable  = cpu_enable_r;
  assign state       = state_r;
  assign pulse_count = pulse_count_r;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Scoreboard bench for cpu_step_controller: expected pulse edges are queued as stimulus is applied.
module tb_cpu_step_controller;

  logic        clock_in = 1'b0;
  logic        reset    = 1'b1;
  logic        run_mode = 1'b0;
  logic        resume   = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_req = 1'b0;
  logic        cpu_enable;
  logic [1:0]  state;
  logic [31:0] pulse_count;

  int total     = 0;
  int bad       = 0;
  int ecnt      = 0;
  int exp_count = 0;
  int exp_q[$];
  int e_run;
  int n_edge;

  localparam int DIV = 4;
  localparam int DEB = 3;

  cpu_step_controller #(
    .DIVISOR         (28'd4),
    .DEBOUNCE_CYCLES (20'd3)
  ) dut (
    .clock_in    (clock_in),
    .reset       (reset),
    .run_mode    (run_mode),
    .resume      (resume),
    .step_btn    (step_btn),
    .halt_req    (halt_req),
    .cpu_enable  (cpu_enable),
    .state       (state),
    .pulse_count (pulse_count)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Edge counter: after posedge number k, ecnt == k.
  initial forever begin
    @(posedge clock_in);
    ecnt++;
  end

  // Output monitor: every cycle cpu_enable must match the head of the expected-edge queue.
  initial forever begin
    logic want;
    @(negedge clock_in);
    while (exp_q.size() > 0 && exp_q[0] < ecnt) void'(exp_q.pop_front());
    want = (exp_q.size() > 0) && (exp_q[0] == ecnt);
    chk("cpu_enable", {31'd0, cpu_enable}, {31'd0, want});
    if (want) begin
      void'(exp_q.pop_front());
      exp_count++;
      chk("pulse_count", pulse_count, exp_count);
    end
  end

  task automatic cyc();
    @(negedge clock_in);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (ecnt < target) cyc();
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cyc();
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    run_mode = 1'b0;
    resume   = 1'b0;
    step_btn = 1'b0;
    halt_req = 1'b0;
    exp_q.delete();
    exp_count = 0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_en", {31'd0, cpu_enable}, 32'd0);
    chk("rst_count", pulse_count, 32'd0);
  endtask

  // Pulse resume with run_mode=1; returns the edge that enters RUN.
  task automatic start_run(output int e);
    run_mode = 1'b1;
    resume   = 1'b1;
    cyc();
    resume = 1'b0;
    e = ecnt;
  endtask

  initial begin
    #1;
    // 1: reset then free-run, first pulse at E+DIV, five pulses
    do_reset();
    start_run(e_run);
    chk("t1_state_run", {30'd0, state}, 32'd1);
    for (int i = 1; i <= 5; i++) exp_q.push_back(e_run + i * DIV);
    wait_drain(40);
    run_mode = 1'b0;
    cyc();
    chk("t1_state_paused", {30'd0, state}, 32'd0);
    chk("t1_count", pulse_count, 32'd5);
    repeat (10) cyc();

    // 3: halt collides with terminal count, then step press while halted
    do_reset();
    start_run(e_run);
    exp_q.push_back(e_run + DIV);
    wait_until(e_run + 2 * DIV - 1);
    halt_req = 1'b1;
    cyc();
    chk("t3_state_halted", {30'd0, state}, 32'd2);
    chk("t3_count", pulse_count, 32'd1);
    step_btn = 1'b1;
    repeat (12) cyc();
    step_btn = 1'b0;
    repeat (12) cyc();
    chk("t3_still_halted", {30'd0, state}, 32'd2);
    chk("t3_count_after_btn", pulse_count, 32'd1);

    // 4: resume gating out of HALTED
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("t4_halt_held", {30'd0, state}, 32'd2);
    halt_req = 1'b0;
    resume   = 1'b1;
    cyc();
    resume = 1'b0;
    chk("t4_to_paused", {30'd0, state}, 32'd0);
    cyc();
    chk("t4_paused_wait", {30'd0, state}, 32'd0);
    start_run(e_run);
    chk("t4_to_run", {30'd0, state}, 32'd1);

    // 5a: drop run_mode at div_cnt=2 after one pulse
    exp_q.push_back(e_run + DIV);
    wait_until(e_run + DIV + 2);
    run_mode = 1'b0;
    cyc();
    chk("t5_mode_drop", {30'd0, state}, 32'd0);
    repeat (12) cyc();
    chk("t5_count", pulse_count, 32'd2);

    // 5b: reset on the cycle a pulse would issue
    do_reset();
    start_run(e_run);
    wait_until(e_run + DIV - 1);
    reset = 1'b1;
    exp_q.delete();
    exp_count = 0;
    cyc();
    chk("t5_rst_en", {31'd0, cpu_enable}, 32'd0);
    chk("t5_rst_state", {30'd0, state}, 32'd0);
    chk("t5_rst_count", pulse_count, 32'd0);
    reset    = 1'b0;
    run_mode = 1'b0;
    repeat (8) cyc();

`ifdef CPU_STEP_DEBOUNCE_EN
    // 2: bounce 1-0-1-0 then stable hold; one pulse at N+2+DEB
    do_reset();
    step_btn = 1'b1; cyc();
    step_btn = 1'b0; cyc();
    step_btn = 1'b1; cyc();
    step_btn = 1'b0; cyc();
    step_btn = 1'b1;
    n_edge = ecnt + 1;
    exp_q.push_back(n_edge + 2 + DEB);
    repeat (10) cyc();
    step_btn = 1'b0;
    repeat (10) cyc();
    wait_drain(10);
    chk("t2_count", pulse_count, 32'd1);
    chk("t2_state", {30'd0, state}, 32'd0);
`else
    // 6: no debounce; a 1-cycle high sampled at edge N pulses at N+2
    do_reset();
    step_btn = 1'b1;
    n_edge = ecnt + 1;
    exp_q.push_back(n_edge + 2);
    cyc();
    step_btn = 1'b0;
    repeat (8) cyc();
    wait_drain(10);
    chk("t6_count", pulse_count, 32'd1);
    chk("t6_state", {30'd0, state}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d expected=finish", ecnt);
    $fatal(1);
  end

endmodule
